jk_ff_monitor: RTL and testbench

JK_FF_MONITOR -- requirements
Module: jk_ff_monitor

---
 rtl/jk_pkg.sv | 38 +++
 rtl/jk_sat_counter.sv | 35 +++
 rtl/jk_ff_monitor.sv | 101 ++++++++++
 tb/tb_jk_ff_monitor.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jk_pkg.sv
// Shared definitions for JK flip-flop checking: monitor FSM states, error/coverage bit
// positions and the JK next-state reference function.
package jk_pkg;

  typedef enum logic {
    UNSYNC = 1'b0,
    CHECK  = 1'b1
  } jk_state_e;

  localparam int unsigned ErrCodeW = 2;
  localparam int unsigned ErrQ     = 0;
  localparam int unsigned ErrQb    = 1;

  localparam int unsigned CovW      = 5;
  localparam int unsigned CovHold   = 0;
  localparam int unsigned CovReset  = 1;
  localparam int unsigned CovSet    = 2;
  localparam int unsigned CovToggle = 3;
  localparam int unsigned CovObsRst = 4;

  // Next q of a JK flop with an active-high synchronous reset that overrides J/K.
  function automatic logic jk_next(input logic q, input logic j, input logic k,
                                   input logic rst);
    logic nxt;
    if (rst) begin
      nxt = 1'b0;
    end else begin
      case ({j, k})
        2'b00:   nxt = q;
        2'b01:   nxt = 1'b0;
        2'b10:   nxt = 1'b1;
        default: nxt = ~q;
      endcase
    end
    return nxt;
  endfunction

endpackage

// File: rtl/jk_sat_counter.sv
// Saturating up-counter with a synchronous clear that wins over a same-cycle increment.
module jk_sat_counter #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W-1:0] CntMax = '1;

  logic [CNT_W-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != CntMax)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/jk_ff_monitor.sv
// Runtime checker for an external JK flop: predicts q one edge ahead, checks qb against q,
// counts errors and records which J/K/reset modes have been exercised.
module jk_ff_monitor
  import jk_pkg::*;
#(
  parameter int unsigned CNT_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                clr,
  input  logic                obs_rst,
  input  logic                j,
  input  logic                k,
  input  logic                q,
  input  logic                qb,
  output logic                err,
  output logic [ErrCodeW-1:0] err_code,
  output logic [CNT_W-1:0]    err_cnt,
  output logic [CovW-1:0]     cov,
  output logic                cov_all,
  output logic                synced
);

  jk_state_e           state_q;
  logic                exp_q;
  logic                err_q;
  logic [ErrCodeW-1:0] code_q;
  logic [CovW-1:0]     cov_q;

  logic [ErrCodeW-1:0] bits;
  logic [CovW-1:0]     cov_hit;
  logic                err_inc;

  always_comb begin
    bits = '0;
    // q is only comparable once a prediction has been loaded.
    bits[ErrQ]  = (state_q == CHECK) && (q != exp_q);
    bits[ErrQb] = (qb == q);

    cov_hit = '0;
    if (obs_rst) begin
      cov_hit[CovObsRst] = 1'b1;
    end else begin
      case ({j, k})
        2'b00:   cov_hit[CovHold]   = 1'b1;
        2'b01:   cov_hit[CovReset]  = 1'b1;
        2'b10:   cov_hit[CovSet]    = 1'b1;
        default: cov_hit[CovToggle] = 1'b1;
      endcase
    end
  end

  assign err_inc = en && (bits != '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= UNSYNC;
      exp_q   <= 1'b0;
      err_q   <= 1'b0;
      code_q  <= '0;
      cov_q   <= '0;
    end else begin
      if (en) begin
        state_q <= CHECK;
        // Always predict from the flop's actual q so one fault is reported once.
        exp_q   <= jk_next(q, j, k, obs_rst);
        err_q   <= err_inc;
        if (err_inc) begin
          code_q <= bits;
        end
      end else begin
        state_q <= UNSYNC;
        err_q   <= 1'b0;
      end

      if (clr) begin
        cov_q <= '0;
      end else if (en) begin
        cov_q <= cov_q | cov_hit;
      end
    end
  end

  jk_sat_counter #(
    .CNT_W (CNT_W)
  ) u_err_cnt (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .inc (err_inc),
    .cnt (err_cnt)
  );

  assign err      = err_q;
  assign err_code = code_q;
  assign cov      = cov_q;
  assign cov_all  = &cov_q;
  assign synced   = (state_q == CHECK);

endmodule

// File: tb/tb_jk_ff_monitor.sv
// Bench for jk_ff_monitor: a behavioural JK flop with injectable faults feeds the monitor,
// and a per-edge expectation queue is compared against the outputs after every edge.
module tb_jk_ff_monitor;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0, clr = 1'b0, obs_rst = 1'b0, j = 1'b0, k = 1'b0;
  logic       q, qb;
  logic       err;
  logic [1:0] err_code;
  logic [7:0] err_cnt;
  logic [4:0] cov;
  logic       cov_all, synced;
  logic       err2, cov_all2, synced2;
  logic [1:0] err_code2;
  logic [1:0] err_cnt2;
  logic [4:0] cov2;

  // 0 good flop, 1 holds on jk=11, 2 qb tied to q, 3 q inverted
  int         fault = 0;
  logic       fq = 1'b0;

  int checks = 0;
  int errors = 0;
  logic err_seen = 1'b0;

  typedef struct {
    logic       err;
    logic [1:0] code;
    int         cnt;
    int         cnt2;
    logic [4:0] cov;
    logic       cov_all;
    logic       synced;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  logic       m_sync = 1'b0, m_exp = 1'b0, m_err = 1'b0;
  logic [1:0] m_code = '0;
  logic [4:0] m_cov = '0;
  int         m_cnt = 0, m_cnt2 = 0;

  always #5 clk = ~clk;

  jk_ff_monitor #(.CNT_W(8)) dut (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .obs_rst(obs_rst), .j(j), .k(k), .q(q), .qb(qb),
    .err(err), .err_code(err_code), .err_cnt(err_cnt), .cov(cov), .cov_all(cov_all),
    .synced(synced)
  );

  jk_ff_monitor #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .obs_rst(obs_rst), .j(j), .k(k), .q(q), .qb(qb),
    .err(err2), .err_code(err_code2), .err_cnt(err_cnt2), .cov(cov2), .cov_all(cov_all2),
    .synced(synced2)
  );

  // Observed flop
  always @(posedge clk) begin
    logic nxt;
    if (obs_rst) nxt = 1'b0;
    else if (j && k) nxt = (fault == 1) ? fq : ~fq;
    else if (j) nxt = 1'b1;
    else if (k) nxt = 1'b0;
    else nxt = fq;
    if (fault == 3) nxt = ~nxt;
    fq <= nxt;
  end

  assign q  = fq;
  assign qb = (fault == 2) ? fq : ~fq;

  // Scoreboard: one expectation per driven edge
  always @(posedge clk) begin
    #1;
    if (sb.size() != 0) begin
      mon_e = sb.pop_front();
      checks++;
      if (err !== mon_e.err) begin
        errors++; $display("FAIL sb_err t=%0t got %b exp %b", $time, err, mon_e.err);
      end
      checks++;
      if (err_code !== mon_e.code) begin
        errors++; $display("FAIL sb_code t=%0t got %b exp %b", $time, err_code, mon_e.code);
      end
      checks++;
      if (err_cnt !== 8'(mon_e.cnt)) begin
        errors++; $display("FAIL sb_cnt t=%0t got %0d exp %0d", $time, err_cnt, mon_e.cnt);
      end
      checks++;
      if (err_cnt2 !== 2'(mon_e.cnt2)) begin
        errors++; $display("FAIL sb_cnt2 t=%0t got %0d exp %0d", $time, err_cnt2, mon_e.cnt2);
      end
      checks++;
      if (cov !== mon_e.cov || cov_all !== mon_e.cov_all) begin
        errors++;
        $display("FAIL sb_cov t=%0t got %b/%b exp %b/%b", $time, cov, cov_all, mon_e.cov,
                 mon_e.cov_all);
      end
      checks++;
      if (synced !== mon_e.synced) begin
        errors++; $display("FAIL sb_synced t=%0t got %b exp %b", $time, synced, mon_e.synced);
      end
    end
    if (err === 1'b1) err_seen = 1'b1;
  end

  // Drive one edge's inputs, predict the post-edge outputs, then let the edge happen.
  task automatic step(input logic s_en, input logic s_clr, input logic s_orst,
                      input logic s_j, input logic s_k);
    logic [1:0] bits;
    exp_t e;
    en = s_en; clr = s_clr; obs_rst = s_orst; j = s_j; k = s_k;
    #1;
    bits = 2'b00;
    if (s_en) begin
      if (m_sync && (q !== m_exp)) bits[0] = 1'b1;
      if (qb === q) bits[1] = 1'b1;
      if (s_orst) m_exp = 1'b0;
      else if ({s_j, s_k} == 2'b00) m_exp = q;
      else if ({s_j, s_k} == 2'b01) m_exp = 1'b0;
      else if ({s_j, s_k} == 2'b10) m_exp = 1'b1;
      else m_exp = ~q;
      m_sync = 1'b1;
      if (s_orst) m_cov[4] = 1'b1;
      else m_cov[{s_j, s_k}] = 1'b1;
      m_err = (bits != 2'b00);
      if (m_err) begin
        m_code = bits;
        if (m_cnt < 255) m_cnt++;
        if (m_cnt2 < 3) m_cnt2++;
      end
    end else begin
      m_sync = 1'b0;
      m_err  = 1'b0;
    end
    if (s_clr) begin
      m_cnt = 0; m_cnt2 = 0; m_cov = '0;
    end
    e.err = m_err; e.code = m_code; e.cnt = m_cnt; e.cnt2 = m_cnt2;
    e.cov = m_cov; e.cov_all = &m_cov; e.synced = m_sync;
    sb.push_back(e);
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if ({err, err_code, err_cnt, cov, cov_all, synced} !== 18'd0) begin
      errors++;
      $display("FAIL reset_outputs got %b exp 0", {err, err_code, err_cnt, cov, cov_all, synced});
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_coverage();
    err_seen = 1'b0;
    fault = 0;
    step(1, 0, 1, 0, 0);
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 1);
    step(1, 0, 0, 1, 0);
    step(1, 0, 0, 1, 1);
    step(1, 0, 0, 1, 1);
    step(1, 0, 0, 1, 0);
    checks++;
    if (cov !== 5'b11111 || cov_all !== 1'b1) begin
      errors++; $display("FAIL cov_full got %b/%b exp 11111/1", cov, cov_all);
    end
    checks++;
    if (err_seen !== 1'b0 || err_cnt !== 8'd0) begin
      errors++; $display("FAIL good_flop_no_err got seen=%b cnt=%0d exp 0/0", err_seen, err_cnt);
    end
  endtask

  task automatic test_hold_fault();
    step(1, 1, 0, 0, 0);
    fault = 1;
    step(1, 0, 0, 1, 1);
    checks++;
    if (err !== 1'b0) begin
      errors++; $display("FAIL hold_early got %b exp 0", err);
    end
    step(1, 0, 0, 0, 0);
    checks++;
    if (err !== 1'b1 || err_code !== 2'b01 || err_cnt !== 8'd1) begin
      errors++;
      $display("FAIL hold_flag got err=%b code=%b cnt=%0d exp 1/01/1", err, err_code, err_cnt);
    end
    fault = 0;
    step(1, 0, 0, 0, 0);
    checks++;
    if (err !== 1'b0 || err_code !== 2'b01) begin
      errors++; $display("FAIL hold_pulse_end got err=%b code=%b exp 0/01", err, err_code);
    end
  endtask

  task automatic test_qb_fault();
    step(0, 1, 0, 0, 0);
    fault = 2;
    step(1, 0, 0, 0, 0);
    checks++;
    if (err !== 1'b1 || err_code !== 2'b10 || err_cnt !== 8'd1) begin
      errors++;
      $display("FAIL qb_first got err=%b code=%b cnt=%0d exp 1/10/1", err, err_code, err_cnt);
    end
    for (int i = 2; i <= 4; i++) begin
      step(1, 0, 0, 0, 0);
      checks++;
      if (err_cnt !== 8'(i)) begin
        errors++; $display("FAIL qb_count got %0d exp %0d", err_cnt, i);
      end
    end
    fault = 0;
  endtask

  task automatic test_saturation();
    fault = 2;
    step(1, 1, 0, 0, 0);
    for (int i = 1; i <= 6; i++) begin
      step(1, 0, 0, 0, 0);
      if (i >= 3) begin
        checks++;
        if (err_cnt2 !== 2'd3) begin
          errors++; $display("FAIL sat_hold edge=%0d got %0d exp 3", i, err_cnt2);
        end
      end
    end
    checks++;
    if (err_cnt !== 8'd6) begin
      errors++; $display("FAIL sat_wide got %0d exp 6", err_cnt);
    end
    step(1, 1, 0, 0, 0);
    checks++;
    if (err_cnt2 !== 2'd0 || err_cnt !== 8'd0 || cov !== 5'd0) begin
      errors++;
      $display("FAIL sat_clr got %0d/%0d cov=%b exp 0/0/0", err_cnt2, err_cnt, cov);
    end
    fault = 0;
  endtask

  task automatic test_en_drop();
    fault = 3;
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 1, 0);
      checks++;
      if (err !== 1'b0 || synced !== 1'b0) begin
        errors++; $display("FAIL en_off got err=%b synced=%b exp 0/0", err, synced);
      end
    end
    step(1, 0, 0, 1, 0);
    checks++;
    if (synced !== 1'b1 || err !== 1'b0) begin
      errors++; $display("FAIL en_resync got synced=%b err=%b exp 1/0", synced, err);
    end
    step(1, 0, 0, 1, 0);
    checks++;
    if (err !== 1'b1 || err_code !== 2'b01) begin
      errors++; $display("FAIL en_resume got err=%b code=%b exp 1/01", err, err_code);
    end
    fault = 0;
    step(1, 0, 0, 0, 0);
  endtask

  task automatic test_reset_mid();
    fault = 2;
    step(1, 1, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 0);
    checks++;
    if (err_cnt !== 8'd5) begin
      errors++; $display("FAIL rst_pre_cnt got %0d exp 5", err_cnt);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if ({err, err_code, err_cnt, cov, cov_all, synced} !== 18'd0 || err_cnt2 !== 2'd0) begin
      errors++;
      $display("FAIL rst_async got %b/%0d exp 0", {err, err_code, err_cnt, cov, cov_all, synced},
               err_cnt2);
    end
    m_sync = 1'b0; m_exp = 1'b0; m_err = 1'b0; m_code = '0; m_cov = '0; m_cnt = 0; m_cnt2 = 0;
    fault = 0;
    @(negedge clk);
    rst = 1'b1;
    step(1, 0, 0, 1, 1);
    checks++;
    if (synced !== 1'b1 || err !== 1'b0) begin
      errors++; $display("FAIL rst_restart got synced=%b err=%b exp 1/0", synced, err);
    end
    step(1, 0, 0, 1, 1);
    step(1, 0, 0, 0, 1);
  endtask

  initial begin
    test_reset();
    test_coverage();
    test_hold_fault();
    test_qb_fault();
    test_saturation();
    test_en_drop();
    test_reset_mid();
    repeat (2) @(posedge clk);
    #3;
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL sb_drain got %0d exp 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
